// File: rtl/clkgen_pkg.sv
// clkgen: shared types for the clock-mode controller.
// Optional cog-cycle counter: CLKGEN_CNT_EN.
package clkgen_pkg;

  typedef enum logic [2:0] {
    RCFAST = 3'd0,
    RCSLOW = 3'd1,
    XINPUT = 3'd2,
    XPLL1  = 3'd3,
    XPLL2  = 3'd4,
    XPLL4  = 3'd5,
    XPLL8  = 3'd6,
    XPLL16 = 3'd7
  } clksel_e;

  localparam int CFG_PLLENA = 6;
  localparam int CFG_OSCENA = 5;
  localparam int CFG_OSCM   = 3;
  localparam int CFG_SEL    = 0;

  // RCSLOW has its own divider tap; 0 is a don't-care for it.
  function automatic int tap_of(clksel_e s, int taps);
    int r;
    r = 0;
    unique case (s)
      RCFAST: r = taps - 2;
      RCSLOW: r = 0;
      XINPUT: r = taps - 1;
      XPLL1, XPLL2, XPLL4, XPLL8, XPLL16: begin
        r = 7 - int'(s);
        if (r > taps - 1) r = taps - 1;
      end
    endcase
    if (r < 0) r = 0;
    return r;
  endfunction

endpackage

// File: rtl/clkgen_wait_timer.sv
// clkgen: startup wait timer; counts while start holds, ready after WAIT.
// Dropping start (or raising clear) restarts the wait from zero.
module clkgen_wait_timer
  import clkgen_pkg::*;
#(
  parameter int WAIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic ready
);

  localparam int W = $clog2(WAIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      ready <= 1'b0;
    end else if (clear || !start) begin
      cnt   <= '0;
      ready <= 1'b0;
    end else if (!ready) begin
      if (cnt == W'(WAIT - 1)) ready <= 1'b1;
      else cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clkgen_enable.sv
// clkgen_enable: cog/PLL rates as single-cycle enables off clock_160.
// Optional cog-cycle counter on port cnt: CLKGEN_CNT_EN.
module clkgen_enable
  import clkgen_pkg::*;
#(
  parameter int TAPS       = 5,
  parameter int BASE_DIV   = 2,
  parameter int RCSLOW_DIV = 512,
  parameter int OSC_WAIT   = 160000,
  parameter int PLL_WAIT   = 16000,
  parameter int CNT_W      = 32
) (
  input  logic             clock_160,
  input  logic             nres,
  input  logic [6:0]       cfg,
  output logic             cog_en,
  output logic             pll_tick,
  output logic [2:0]       mode,
  output logic             switch_pending,
  output logic             osc_ready,
  output logic             pll_ready
`ifdef CLKGEN_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  localparam int LB = $clog2(BASE_DIV);
  localparam int LR = $clog2(RCSLOW_DIV);
  localparam int D  = (LB + TAPS - 1 > LR) ? LB + TAPS - 1 : LR;
  localparam logic [D-1:0] SM =
    D'((64'd1 << LR) - 64'd1);

  logic [D-1:0]    div;
  logic [TAPS-1:0] tap_en;
  logic            slow_en;
  logic [6:0]      cfgx;
  logic            pllena;
  logic            oscena;
  logic            unused_oscm;
  clksel_e         req;
  clksel_e         want;
  clksel_e         nxt;
  clksel_e         mode_q;
  logic            want_ok;
  logic            mode_ok;
  logic            src_en;
  logic            pll_start;

  always_ff @(posedge clock_160 or negedge nres) begin
    if (!nres) begin
      div  <= '0;
      cfgx <= '0;
    end else begin
      div  <= div + 1'b1;
      cfgx <= cfg;
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    localparam logic [D-1:0] M =
      D'((64'd1 << (LB + k)) - 64'd1);
    assign tap_en[k] = (div & M) == M;
  end

  assign slow_en  = (div & SM) == SM;
  assign pll_tick = tap_en[0];

  assign pllena      = cfgx[CFG_PLLENA];
  assign oscena      = cfgx[CFG_OSCENA];
  assign unused_oscm = ^cfgx[CFG_OSCM +: 2];
  assign req         = clksel_e'(cfgx[CFG_SEL +: 3]);
  assign pll_start   = pllena & osc_ready;

  clkgen_wait_timer #(.WAIT(OSC_WAIT)) u_osc (
    .clk   (clock_160),
    .rst_n (nres),
    .start (oscena),
    .clear (~oscena),
    .ready (osc_ready)
  );

  clkgen_wait_timer #(.WAIT(PLL_WAIT)) u_pll (
    .clk   (clock_160),
    .rst_n (nres),
    .start (pll_start),
    .clear (~pll_start),
    .ready (pll_ready)
  );

  // Missing enables fall back to RCFAST; missing readiness holds.
  always_comb begin
    want    = req;
    want_ok = 1'b1;
    unique case (1'b1)
      (req >= XPLL1): begin
        if (!(pllena && oscena)) want = RCFAST;
        else want_ok = pll_ready;
      end
      (req == XINPUT): begin
        if (!oscena) want = RCFAST;
        else want_ok = osc_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    mode_ok = 1'b1;
    unique case (1'b1)
      (mode_q >= XPLL1):
        mode_ok = pllena & oscena & pll_ready;
      (mode_q == XINPUT):
        mode_ok = oscena & osc_ready;
      default: ;
    endcase
  end

  always_comb begin
    nxt = mode_q;
    if (want_ok) nxt = want;
    else if (!mode_ok) nxt = RCFAST;
  end

  always_comb begin
    src_en = 1'b0;
    if (mode_q == RCSLOW) begin
      src_en = slow_en;
    end else begin
      for (int k = 0; k < TAPS; k++)
        if (k == tap_of(mode_q, TAPS))
          src_en = tap_en[k];
    end
  end

  // Load on the old source's boundary so no period is truncated.
  always_ff @(posedge clock_160 or negedge nres) begin
    if (!nres) mode_q <= RCFAST;
    else if (src_en) mode_q <= nxt;
  end

  assign cog_en         = src_en;
  assign mode           = mode_q;
  assign switch_pending = (want != mode_q);

`ifdef CLKGEN_CNT_EN
  always_ff @(posedge clock_160 or negedge nres) begin
    if (!nres) cnt <= '0;
    else if (src_en) cnt <= cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_clkgen_enable.sv
// tb_clkgen_enable: scoreboard of expected cog_en pulses per mode.
// Build with CLKGEN_CNT_EN to also check the cog-cycle counter.
module tb_clkgen_enable;

  localparam int OW = 8;
  localparam int PW = 4;

  typedef struct packed {
    logic [2:0] mode;
    int         period;
    logic       gap;
  } exp_t;

  logic       clk;
  logic       nres;
  logic [6:0] cfg;
  logic       cog_en;
  logic       pll_tick;
  logic [2:0] mode;
  logic       switch_pending;
  logic       osc_ready;
  logic       pll_ready;
`ifdef CLKGEN_CNT_EN
  logic [31:0] cnt;
`endif

  logic [8:0] tb_div;
  int         cyc;
  int         last;
  int         n_chk;
  int         n_fail;
  exp_t       sb[$];

  clkgen_enable #(
    .OSC_WAIT (OW),
    .PLL_WAIT (PW)
  ) dut (
    .clock_160      (clk),
    .nres           (nres),
    .cfg            (cfg),
    .cog_en         (cog_en),
    .pll_tick       (pll_tick),
    .mode           (mode),
    .switch_pending (switch_pending),
    .osc_ready      (osc_ready),
    .pll_ready      (pll_ready)
`ifdef CLKGEN_CNT_EN
    ,
    .cnt            (cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge nres) begin
    if (!nres) tb_div <= '0;
    else tb_div <= tb_div + 1'b1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] m,
                      input int p,
                      input logic g);
    exp_t e;
    e.mode   = m;
    e.period = p;
    e.gap    = g;
    sb.push_back(e);
  endtask

  task automatic take_pulse(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (!cog_en && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cog_en) begin
      check({tag, "_timeout"}, 0, 1);
      sb.delete();
      return;
    end
    e = sb.pop_front();
    check({tag, "_mode"}, longint'(mode),
          longint'(e.mode));
    check({tag, "_align"},
          longint'(int'(tb_div) & (e.period - 1)),
          longint'(e.period - 1));
    if (e.gap)
      check({tag, "_gap"}, longint'(cyc - last),
            longint'(e.period));
    last = cyc;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    while (sb.size() > 0) take_pulse(tag);
  endtask

  task automatic wait_rdy(input string tag,
                          input bit pll,
                          input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pll ? pll_ready : osc_ready)
               && n < 1000);
    check(tag, longint'(n), longint'(exp_n));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mode"}, longint'(mode), 0);
    check({tag, "_cog"}, longint'(cog_en), 0);
    check({tag, "_tick"}, longint'(pll_tick), 0);
    check({tag, "_pend"}, longint'(switch_pending), 0);
    check({tag, "_osc"}, longint'(osc_ready), 0);
    check({tag, "_pll"}, longint'(pll_ready), 0);
`ifdef CLKGEN_CNT_EN
    check({tag, "_cnt"}, longint'(cnt), 0);
`endif
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    last   = 0;
    nres   = 1'b0;
    cfg    = 7'h00;
    repeat (3) @(negedge clk);
    check_reset("rst");

    // rcfast after reset, tap-0 reference
    nres = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("pll_tick", longint'(pll_tick),
            longint'(tb_div[0]));
    end
    push(3'd0, 16, 1'b0);
    push(3'd0, 16, 1'b1);
    push(3'd0, 16, 1'b1);
    drain("rcfast");

    // PLLx16 after osc and pll waits
    cfg = 7'h6F;
    wait_rdy("osc_wait", 1'b0, OW + 1);
    check("hold_mode", longint'(mode), 0);
    check("hold_pend", longint'(switch_pending), 1);
    wait_rdy("pll_wait", 1'b1, PW);
    push(3'd0, 16, 1'b0);
    push(3'd7, 2, 1'b1);
    push(3'd7, 2, 1'b1);
    push(3'd7, 2, 1'b1);
    drain("xpll16");
    check("x16_pend", longint'(switch_pending), 0);

    // to RCSLOW at the next tap-0 pulse
    cfg = 7'h21;
    push(3'd7, 2, 1'b1);
    push(3'd1, 512, 1'b0);
    push(3'd1, 512, 1'b1);
    push(3'd1, 512, 1'b1);
    drain("rcslow");

    // back to PLLx16, then drop PLLENA
    cfg = 7'h6F;
    push(3'd1, 512, 1'b1);
    push(3'd7, 2, 1'b0);
    push(3'd7, 2, 1'b1);
    drain("reenter");
    cfg = 7'h27;
    push(3'd7, 2, 1'b1);
    push(3'd0, 16, 1'b0);
    push(3'd0, 16, 1'b1);
    drain("pll_drop");
    check("drop_pll", longint'(pll_ready), 0);
    check("drop_osc", longint'(osc_ready), 1);
    check("drop_pend", longint'(switch_pending), 0);

    // CLKSEL 7 with no enables resolves to RCFAST
    cfg = 7'h07;
    repeat (3) @(negedge clk);
    check("noen_mode", longint'(mode), 0);
    check("noen_pend", longint'(switch_pending), 0);
    check("noen_osc", longint'(osc_ready), 0);
    push(3'd0, 16, 1'b1);
    drain("noen");

    // reset in the middle of the pll wait
    cfg = 7'h6F;
    wait_rdy("osc_wait2", 1'b0, OW + 1);
    repeat (2) @(negedge clk);
    nres = 1'b0;
    #1;
    check_reset("mid_rst");
    @(negedge clk);
    nres = 1'b1;
    wait_rdy("osc_wait3", 1'b0, OW + 1);
    wait_rdy("pll_wait3", 1'b1, PW);
    push(3'd0, 16, 1'b0);
    push(3'd7, 2, 1'b1);
    drain("after_rst");
`ifdef CLKGEN_CNT_EN
    check("cnt_after", longint'(cnt), 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
